retire_trace_unit: RTL and testbench
====================================

# retire_trace_unit

Synthesizable retire-trace producer for the single-cycle/pipelined CPU. It captures one commit record per retiring instruction from the writeback stage and classifies it as REG, LD, ST, NOP/branch or HALT. Each record carries an instruction number, and records are buffered in a FIFO and streamed out over a valid/ready port to a trace sink (logger, UART bridge or checker). It also keeps the cycle and instruction counters, halt/drain sequencing and a run-away cycle limit in hardware.

## Interface
- DEPTH, 8: FIFO depth in records; power of two, at least 2.
- CYCLE_LIMIT, 100000: cycle count at which the run is declared timed out.
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- wb_valid  in  1  an instruction retires this cycle.
- wb_pc, wb_inst  in  16 each  PC and instruction word of the retiring instruction.
- wb_reg_write, wb_mem_read, wb_mem_write, wb_hlt  in  1 each  retire control bits.
- wb_dst_reg  in  4  destination register.
- wb_dst_data  in  16  register write data.
- wb_mem_addr, wb_mem_data  in  16 each  memory address, and store data.
- stall_req  out  1  FIFO full; the CPU must hold retirement while this is high.
- trc_valid  out  1  head record is valid.
- trc_ready  in  1  sink accepts the head record.
- trc_kind  out  3  record kind: 0 NOP, 1 REG, 2 LD, 3 ST, 4 HALT.
- trc_inum  out  32  instruction number.
- trc_pc, trc_inst, trc_value, trc_addr  out  16 each  record fields.
- trc_reg  out  4  record register field.
- inst_count, cycle_count  out  32 each  live counters.
- done, timeout, overflow  out  1 each  sticky status flags.

## Operation
- Kind selection, first match wins:
  - reg_write and mem_read: LD, with reg, value and addr fields.
  - reg_write: REG, with reg and value fields.
  - hlt: HALT.
  - mem_write: ST, with addr and value (value = wb_mem_data).
  - otherwise: NOP.
- Unused fields of a record are 0.
- trc_inum is the value of inst_count before the increment. inst_count increments once per accepted record.
- A record is accepted when wb_valid is high, the state is RUN, and the FIFO count is below DEPTH.
- If wb_valid is high while the FIFO is full: the record is dropped, overflow is set, and inst_count does not change.
- A push and a pop in the same cycle leave count unchanged. A push into a full FIFO is refused even if a pop happens in the same cycle.
- FSM states:
  - RUN to DRAIN when a HALT record is accepted.
  - RUN to TIMEOUT when cycle_count equals CYCLE_LIMIT.
  - DRAIN to DONE when the FIFO is empty.
  - DONE and TIMEOUT are terminal until reset.
- In DRAIN, DONE and TIMEOUT, wb_valid is ignored; no records and no overflow are produced. TIMEOUT still drains the FIFO.
- cycle_count increments in RUN and DRAIN, saturates at 0xFFFFFFFF, and freezes in DONE and TIMEOUT.

## Timing
- Reset (rst_n low at a clk edge): FIFO emptied, all counters 0, state RUN, and every output 0, including trc_* fields and flags.
- Reset mid-run discards all pending records.
- Latency: a record accepted at edge N presents trc_valid=1 from after edge N (show-ahead head).
- A pop occurs at an edge where trc_valid and trc_ready are both high.
- trc_* fields stay stable while trc_valid is high and trc_ready is low.
- stall_req = (count == DEPTH). It is combinational from the registered count, with no input-to-output path.
- done goes high the cycle after the FIFO is empty in DRAIN. timeout goes high the cycle after cycle_count reaches CYCLE_LIMIT.

## Configuration
- TRACE_CYCLE_STAMP_EN defined:
  - Each record also stores cycle_count at acceptance.
  - The record is presented on an extra output port, trc_cycle (out, 32 bits).
- Not defined: the port is absent and the FIFO record width excludes the stamp.

## Structure
- Package trace_pkg holds:
  - enum trc_kind_e;
  - struct trace_rec_t (kind, inum, pc, inst, reg, value, addr, plus the optional cycle stamp);
  - FSM state enum;
  - default CYCLE_LIMIT.
- Sub-module trace_fifo: parameterized synchronous FIFO of trace_rec_t with count, full/empty flags and show-ahead read.

## Test plan
- Reset: hold rst_n low 2 cycles, then release → all outputs 0, stall_req=0, cycle_count=1 after the first free edge.
- REG: pc=0x0002, reg_write, dst 3, data 0x0005, trc_ready=1 → next cycle trc_valid=1, kind=1, inum=0, reg=3, value=0x0005; popped; inst_count=1.
- Mixed stream, one per cycle:
  - LD r4 ← 0x00AA from addr 0x0010 → kind 2, inum 0, addr 0x0010.
  - ST 0x1234 to addr 0x0020 → kind 3, inum 1.
  - branch (no writes) → kind 0, inum 2.
- Back-pressure: trc_ready=0 and 9 retires → stall_req=1 after the 8th, 9th dropped, overflow=1, inst_count=8. Release trc_ready → 8 pops, inum 0..7 in order.
- Halt drain: 2 records pending, trc_ready=0, HALT retires → state DRAIN, later wb_valid ignored. Release trc_ready → 3 pops, last kind 4, then done=1; cycle_count frozen.
- Timeout: CYCLE_LIMIT=20, no halt → timeout=1 one cycle after cycle_count=20; further wb_valid produces no records and inst_count is unchanged.

Source files
------------

// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types for the retire-trace producer:
//   trc_kind_e      record kind encoding seen on trc_kind
//   trace_state_e   halt / drain / timeout sequencing states
//   trace_rec_t     one buffered commit record
//   classify_kind   first-match kind selection from the retire control bits
// Optional feature macro: TRACE_CYCLE_STAMP_EN adds a 32-bit cycle stamp to
// every record.
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int unsigned DEFAULT_CYCLE_LIMIT = 32'd100000;

    typedef enum logic [2:0] {
        KIND_NOP  = 3'd0,
        KIND_REG  = 3'd1,
        KIND_LD   = 3'd2,
        KIND_ST   = 3'd3,
        KIND_HALT = 3'd4
    } trc_kind_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } trace_state_e;

    typedef struct packed {
        trc_kind_e   kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [3:0]  rdst;
        logic [15:0] value;
        logic [15:0] addr;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] cycle;
`endif
    } trace_rec_t;

    // A load also writes a register, so it must be tested before plain REG;
    // a halt wins over a store.
    function automatic trc_kind_e classify_kind(
        input logic reg_write,
        input logic mem_read,
        input logic mem_write,
        input logic hlt
    );
        trc_kind_e kind;
        if (reg_write && mem_read) begin
            kind = KIND_LD;
        end else if (reg_write) begin
            kind = KIND_REG;
        end else if (hlt) begin
            kind = KIND_HALT;
        end else if (mem_write) begin
            kind = KIND_ST;
        end else begin
            kind = KIND_NOP;
        end
        return kind;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous show-ahead FIFO of trace_rec_t records.
//   clk, rst_n  clock and synchronous active-low reset
//   push        write push_data unless full (a same-cycle pop does not help)
//   pop         retire the head record unless empty
//   head        current head record, all-zero while empty
//   count       occupancy, 0..DEPTH
//   full/empty  occupancy flags
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  trace_rec_t             push_data,
    input  logic                   pop,
    output trace_rec_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    trace_rec_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Record storage; needs no reset because empty slots are never shown.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Show-ahead head, forced to zero while empty so stale slots never leak.
    always_comb begin
        head = '0;
        if (empty) begin
            head = '0;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/retire_trace_unit.sv
// -----------------------------------------------------------------------------
// retire_trace_unit
// Captures one commit record per retiring instruction, classifies it
// (NOP/REG/LD/ST/HALT), numbers it, buffers it and streams it to a trace sink
// over valid/ready. Also keeps instruction/cycle counters, halt drain
// sequencing and a run-away cycle limit.
//   clk, rst_n          clock, synchronous active-low reset
//   wb_*                retire information from writeback
//   stall_req           FIFO full, CPU must hold retirement
//   trc_valid/trc_ready head record handshake
//   trc_kind..trc_reg   head record fields
//   inst_count          accepted records so far
//   cycle_count         cycles spent in RUN/DRAIN, saturating
//   done/timeout        terminal states reached
//   overflow            a retire was dropped on a full FIFO (sticky)
// Optional feature macro: TRACE_CYCLE_STAMP_EN adds output trc_cycle with the
// cycle_count value captured when the record was accepted.
// -----------------------------------------------------------------------------
module retire_trace_unit
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [15:0] wb_pc,
    input  logic [15:0] wb_inst,
    input  logic        wb_reg_write,
    input  logic        wb_mem_read,
    input  logic        wb_mem_write,
    input  logic        wb_hlt,
    input  logic [3:0]  wb_dst_reg,
    input  logic [15:0] wb_dst_data,
    input  logic [15:0] wb_mem_addr,
    input  logic [15:0] wb_mem_data,
    output logic        stall_req,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [2:0]  trc_kind,
    output logic [31:0] trc_inum,
    output logic [15:0] trc_pc,
    output logic [15:0] trc_inst,
    output logic [15:0] trc_value,
    output logic [15:0] trc_addr,
    output logic [3:0]  trc_reg,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [31:0] trc_cycle,
`endif
    output logic [31:0] inst_count,
    output logic [31:0] cycle_count,
    output logic        done,
    output logic        timeout,
    output logic        overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    trace_state_e     state_r;
    trace_state_e     state_next_s;
    logic [31:0]      inst_count_r;
    logic [31:0]      cycle_count_r;
    logic             overflow_r;
    trc_kind_e        kind_s;
    trace_rec_t       rec_s;
    trace_rec_t       head_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             in_run_s;
    logic             accept_s;
    logic             drop_s;
    logic             pop_s;

    assign in_run_s = (state_r == ST_RUN);
    assign accept_s = wb_valid && in_run_s && !fifo_full_s;
    assign drop_s   = wb_valid && in_run_s && fifo_full_s;
    assign pop_s    = trc_ready && !fifo_empty_s;

    // Build the record for the retiring instruction; fields a kind does not
    // use stay zero.
    always_comb begin
        kind_s     = classify_kind(wb_reg_write, wb_mem_read, wb_mem_write, wb_hlt);
        rec_s      = '0;
        rec_s.kind = kind_s;
        rec_s.inum = inst_count_r;
        rec_s.pc   = wb_pc;
        rec_s.inst = wb_inst;
`ifdef TRACE_CYCLE_STAMP_EN
        rec_s.cycle = cycle_count_r;
`endif
        case (kind_s)
            KIND_LD: begin
                rec_s.rdst  = wb_dst_reg;
                rec_s.value = wb_dst_data;
                rec_s.addr  = wb_mem_addr;
            end
            KIND_REG: begin
                rec_s.rdst  = wb_dst_reg;
                rec_s.value = wb_dst_data;
            end
            KIND_ST: begin
                rec_s.value = wb_mem_data;
                rec_s.addr  = wb_mem_addr;
            end
            default: begin
                rec_s.rdst = 4'd0;
            end
        endcase
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept_s),
        .push_data (rec_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Sequencing state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: the cycle limit takes priority over an accepted halt.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (cycle_count_r == CYCLE_LIMIT) begin
                    state_next_s = ST_TIMEOUT;
                end else if (accept_s && (kind_s == KIND_HALT)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:    state_next_s = ST_DONE;
            ST_TIMEOUT: state_next_s = ST_TIMEOUT;
            default:    state_next_s = ST_RUN;
        endcase
    end

    // Instruction/cycle counters and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_count_r  <= 32'd0;
            cycle_count_r <= 32'd0;
            overflow_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                inst_count_r <= inst_count_r + 32'd1;
            end
            if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
                (cycle_count_r != 32'hFFFF_FFFF)) begin
                cycle_count_r <= cycle_count_r + 32'd1;
            end
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign stall_req   = (fifo_count_s == CNT_W'(DEPTH));
    assign trc_valid   = !fifo_empty_s;
    assign trc_kind    = head_s.kind;
    assign trc_inum    = head_s.inum;
    assign trc_pc      = head_s.pc;
    assign trc_inst    = head_s.inst;
    assign trc_value   = head_s.value;
    assign trc_addr    = head_s.addr;
    assign trc_reg     = head_s.rdst;
`ifdef TRACE_CYCLE_STAMP_EN
    assign trc_cycle   = head_s.cycle;
`endif
    assign inst_count  = inst_count_r;
    assign cycle_count = cycle_count_r;
    assign done        = (state_r == ST_DONE);
    assign timeout     = (state_r == ST_TIMEOUT);
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_retire_trace_unit.sv
// -----------------------------------------------------------------------------
// tb_retire_trace_unit
// Directed bench for retire_trace_unit. Expected records are queued when a
// retire is driven and compared against the head whenever a pop handshake
// happens. A second instance with a short cycle limit covers the timeout path.
// -----------------------------------------------------------------------------
module tb_retire_trace_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [15:0] wb_pc;
    logic [15:0] wb_inst;
    logic        wb_reg_write;
    logic        wb_mem_read;
    logic        wb_mem_write;
    logic        wb_hlt;
    logic [3:0]  wb_dst_reg;
    logic [15:0] wb_dst_data;
    logic [15:0] wb_mem_addr;
    logic [15:0] wb_mem_data;
    logic        trc_ready;
    logic        t_trc_ready;

    logic        stall_req, trc_valid, done, timeout, overflow;
    logic [2:0]  trc_kind;
    logic [31:0] trc_inum, inst_count, cycle_count;
    logic [15:0] trc_pc, trc_inst, trc_value, trc_addr;
    logic [3:0]  trc_reg;

    logic        t_stall_req, t_trc_valid, t_done, t_timeout, t_overflow;
    logic [2:0]  t_trc_kind;
    logic [31:0] t_trc_inum, t_inst_count, t_cycle_count;
    logic [15:0] t_trc_pc, t_trc_inst, t_trc_value, t_trc_addr;
    logic [3:0]  t_trc_reg;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] trc_cycle, t_trc_cycle;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [3:0]  rg;
        logic [15:0] value;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    retire_trace_unit #(.DEPTH(8)) dut (
        .clk(clk),
`ifdef TRACE_CYCLE_STAMP_EN
        .trc_cycle(trc_cycle),
`endif
        .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_reg_write(wb_reg_write), .wb_mem_read(wb_mem_read),
        .wb_mem_write(wb_mem_write), .wb_hlt(wb_hlt), .wb_dst_reg(wb_dst_reg),
        .wb_dst_data(wb_dst_data), .wb_mem_addr(wb_mem_addr),
        .wb_mem_data(wb_mem_data), .stall_req(stall_req), .trc_valid(trc_valid),
        .trc_ready(trc_ready), .trc_kind(trc_kind), .trc_inum(trc_inum),
        .trc_pc(trc_pc), .trc_inst(trc_inst), .trc_value(trc_value),
        .trc_addr(trc_addr), .trc_reg(trc_reg), .inst_count(inst_count),
        .cycle_count(cycle_count), .done(done), .timeout(timeout),
        .overflow(overflow)
    );

    retire_trace_unit #(.DEPTH(8), .CYCLE_LIMIT(20)) tdut (
        .clk(clk),
`ifdef TRACE_CYCLE_STAMP_EN
        .trc_cycle(t_trc_cycle),
`endif
        .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_reg_write(wb_reg_write), .wb_mem_read(wb_mem_read),
        .wb_mem_write(wb_mem_write), .wb_hlt(wb_hlt), .wb_dst_reg(wb_dst_reg),
        .wb_dst_data(wb_dst_data), .wb_mem_addr(wb_mem_addr),
        .wb_mem_data(wb_mem_data), .stall_req(t_stall_req),
        .trc_valid(t_trc_valid), .trc_ready(t_trc_ready), .trc_kind(t_trc_kind),
        .trc_inum(t_trc_inum), .trc_pc(t_trc_pc), .trc_inst(t_trc_inst),
        .trc_value(t_trc_value), .trc_addr(t_trc_addr), .trc_reg(t_trc_reg),
        .inst_count(t_inst_count), .cycle_count(t_cycle_count), .done(t_done),
        .timeout(t_timeout), .overflow(t_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_rec(input logic [2:0] kind, input logic [31:0] inum,
                              input logic [15:0] pc, input logic [15:0] inst,
                              input logic [3:0] rg, input logic [15:0] value,
                              input logic [15:0] addr);
        exp_t e;
        e.kind = kind; e.inum = inum; e.pc = pc; e.inst = inst;
        e.rg = rg; e.value = value; e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Compare the head against the scoreboard if it is popped at the coming
    // edge, then advance one clock and settle past the edge.
    task automatic tick();
        exp_t e;
        if (trc_valid === 1'b1 && trc_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(trc_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pop_kind",  32'(trc_kind),  32'(e.kind));
                check("pop_inum",  trc_inum,       e.inum);
                check("pop_pc",    32'(trc_pc),    32'(e.pc));
                check("pop_inst",  32'(trc_inst),  32'(e.inst));
                check("pop_reg",   32'(trc_reg),   32'(e.rg));
                check("pop_value", 32'(trc_value), 32'(e.value));
                check("pop_addr",  32'(trc_addr),  32'(e.addr));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wb_valid = 1'b0; wb_pc = 16'h0000; wb_inst = 16'h0000;
        wb_reg_write = 1'b0; wb_mem_read = 1'b0; wb_mem_write = 1'b0;
        wb_hlt = 1'b0; wb_dst_reg = 4'h0; wb_dst_data = 16'h0000;
        wb_mem_addr = 16'h0000; wb_mem_data = 16'h0000;
    endtask

    task automatic retire(input logic rw, input logic mr, input logic mw, input logic hl,
                          input logic [15:0] pc, input logic [15:0] inst,
                          input logic [3:0] dst, input logic [15:0] dd,
                          input logic [15:0] ma, input logic [15:0] md);
        wb_valid = 1'b1; wb_reg_write = rw; wb_mem_read = mr; wb_mem_write = mw;
        wb_hlt = hl; wb_pc = pc; wb_inst = inst; wb_dst_reg = dst;
        wb_dst_data = dd; wb_mem_addr = ma; wb_mem_data = md;
    endtask

    task automatic do_reset();
        trc_ready = 1'b0;
        t_trc_ready = 1'b0;
        set_idle();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held for two edges.
        rst_n = 1'b0; trc_ready = 1'b0; t_trc_ready = 1'b0;
        set_idle();
        tick();
        tick();
        check("rst_trc_valid",   32'(trc_valid), 32'd0);
        check("rst_stall_req",   32'(stall_req), 32'd0);
        check("rst_inst_count",  inst_count,     32'd0);
        check("rst_cycle_count", cycle_count,    32'd0);
        check("rst_flags",       {29'd0, done, timeout, overflow}, 32'd0);
        check("rst_trc_fields",  {13'd0, trc_kind, trc_reg, trc_pc}, 32'd0);
        check("rst_trc_inum",    trc_inum, 32'd0);
        rst_n = 1'b1;
        tick();
        check("cycle_after_first_edge", cycle_count, 32'd1);

        // Single REG retire with a garbage address that must not appear.
        trc_ready = 1'b1;
        retire(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h1350, 4'd3, 16'h0005, 16'h00EE, 16'h00DD);
        expect_rec(3'd1, 32'd0, 16'h0002, 16'h1350, 4'd3, 16'h0005, 16'h0000);
        tick();
        set_idle();
        check("reg_valid", 32'(trc_valid), 32'd1);
        check("reg_kind",  32'(trc_kind),  32'd1);
        check("reg_inum",  trc_inum,       32'd0);
        check("reg_reg",   32'(trc_reg),   32'd3);
        check("reg_value", 32'(trc_value), 32'h0005);
        check("reg_addr",  32'(trc_addr),  32'h0000);
        tick();
        check("reg_inst_count", inst_count, 32'd1);
        check("reg_popped", 32'(trc_valid), 32'd0);

        // Mixed LD / ST / branch, one per cycle.
        do_reset();
        trc_ready = 1'b1;
        retire(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h4410, 4'd4, 16'h00AA, 16'h0010, 16'h0BAD);
        expect_rec(3'd2, 32'd0, 16'h0010, 16'h4410, 4'd4, 16'h00AA, 16'h0010);
        tick();
        retire(1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h5520, 4'd9, 16'h7777, 16'h0020, 16'h1234);
        expect_rec(3'd3, 32'd1, 16'h0012, 16'h5520, 4'd0, 16'h1234, 16'h0020);
        tick();
        retire(1'b0, 1'b0, 1'b0, 1'b0, 16'h0014, 16'hC003, 4'd7, 16'h6666, 16'h0055, 16'h0044);
        expect_rec(3'd0, 32'd2, 16'h0014, 16'hC003, 4'd0, 16'h0000, 16'h0000);
        tick();
        set_idle();
        tick();
        tick();
        check("mix_inst_count", inst_count, 32'd3);
        check("mix_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure: fill, overflow, refused push at full with a pop.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            retire(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0100 + i), 16'h2000, 4'(i),
                   16'(i * 16 + 1), 16'h0000, 16'h0000);
            if (i < 8) begin
                expect_rec(3'd1, 32'(i), 16'(16'h0100 + i), 16'h2000, 4'(i),
                           16'(i * 16 + 1), 16'h0000);
            end
            tick();
            if (i == 6) begin
                check("bp_stall_at_7", 32'(stall_req), 32'd0);
            end
        end
        set_idle();
        check("bp_stall_full",  32'(stall_req), 32'd1);
        check("bp_overflow",    32'(overflow),  32'd1);
        check("bp_inst_count",  inst_count,     32'd8);
        check("bp_head_inum",   trc_inum,       32'd0);
        trc_ready = 1'b1;
        retire(1'b1, 1'b0, 1'b0, 1'b0, 16'h01FF, 16'h2FFF, 4'd15, 16'hFFFF, 16'h0000, 16'h0000);
        tick();
        set_idle();
        check("bp_full_push_refused", inst_count, 32'd8);
        check("bp_stall_after_pop", 32'(stall_req), 32'd0);
        repeat (7) tick();
        check("bp_empty", 32'(trc_valid), 32'd0);
        check("bp_all_popped", 32'(exp_q.size()), 32'd0);

        // Halt drain.
        do_reset();
        retire(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h3001, 4'd1, 16'h0011, 16'h0000, 16'h0000);
        expect_rec(3'd1, 32'd0, 16'h0020, 16'h3001, 4'd1, 16'h0011, 16'h0000);
        tick();
        retire(1'b1, 1'b0, 1'b0, 1'b0, 16'h0022, 16'h3002, 4'd2, 16'h0022, 16'h0000, 16'h0000);
        expect_rec(3'd1, 32'd1, 16'h0022, 16'h3002, 4'd2, 16'h0022, 16'h0000);
        tick();
        retire(1'b0, 1'b0, 1'b1, 1'b1, 16'h0030, 16'hF000, 4'd5, 16'h5555, 16'h0066, 16'h0077);
        expect_rec(3'd4, 32'd2, 16'h0030, 16'hF000, 4'd0, 16'h0000, 16'h0000);
        tick();
        retire(1'b1, 1'b0, 1'b0, 1'b0, 16'h0032, 16'h3003, 4'd3, 16'h0033, 16'h0000, 16'h0000);
        tick();
        tick();
        set_idle();
        check("halt_inst_count", inst_count,     32'd3);
        check("halt_no_overflow", 32'(overflow), 32'd0);
        check("halt_not_done",   32'(done),      32'd0);
        check("halt_cycles",     cycle_count,    32'd5);
        trc_ready = 1'b1;
        tick();
        tick();
        tick();
        check("halt_fifo_empty", 32'(trc_valid), 32'd0);
        check("halt_done_wait",  32'(done),      32'd0);
        tick();
        check("halt_done",        32'(done),  32'd1);
        check("halt_cycles_done", cycle_count, 32'd9);
        tick();
        tick();
        check("halt_cycles_frozen", cycle_count, 32'd9);
        check("halt_all_popped", 32'(exp_q.size()), 32'd0);

        // Timeout on the short-limit instance; one record left pending.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                retire(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h3404, 4'd2, 16'h0022, 16'h0000, 16'h0000);
            end else begin
                set_idle();
            end
            tick();
        end
        set_idle();
        check("to_cycle_at_limit", t_cycle_count, 32'd20);
        check("to_not_yet",        32'(t_timeout), 32'd0);
        check("to_pending",        32'(t_trc_valid), 32'd1);
        check("to_pending_value",  32'(t_trc_value), 32'h0022);
        tick();
        check("to_timeout",  32'(t_timeout), 32'd1);
        check("to_cycle_21", t_cycle_count,  32'd21);
        retire(1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 16'h3505, 4'd6, 16'h0066, 16'h0000, 16'h0000);
        tick();
        tick();
        set_idle();
        check("to_inst_count",  t_inst_count,     32'd1);
        check("to_no_overflow", 32'(t_overflow),  32'd0);
        t_trc_ready = 1'b1;
        tick();
        check("to_drained",      32'(t_trc_valid), 32'd0);
        check("to_cycle_frozen", t_cycle_count,    32'd21);
        check("to_not_done",     32'(t_done),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
